// File: rtl/fifo_mem_ctrl.sv
// Pointer, occupancy and flag controller that runs a dual-pointer memory as a circular FIFO.
// Define FIFO_ERR_EN to build the sticky overflow/underflow error flags; otherwise they are tied to 0.
module fifo_mem_ctrl #(
   parameter int unsigned MAIN_SIZE = 8,
   parameter int unsigned DATA_SIZE = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [MAIN_SIZE:0]   almost_full_thr,
   input  logic [MAIN_SIZE:0]   almost_empty_thr,
   output logic                 write,
   output logic                 read,
   output logic [MAIN_SIZE-1:0] wr_ptr,
   output logic [MAIN_SIZE-1:0] rd_ptr,
   output logic [MAIN_SIZE:0]   count,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 rd_valid,
   output logic                 err_overflow,
   output logic                 err_underflow
);

   localparam int unsigned DEPTH = 1 << MAIN_SIZE;
   localparam int unsigned CW    = MAIN_SIZE + 1;

   // The word width belongs to the attached memory; only sanity-check it here.
   if (DATA_SIZE < 1) begin : g_bad_data_size
      $error("fifo_mem_ctrl: DATA_SIZE must be at least 1");
   end

   logic push_acc;
   logic pop_acc;

   // Flags and accept decisions all come from the registered occupancy.
   always_comb begin
      full         = (count == CW'(DEPTH));
      empty        = (count == CW'(0));
      almost_full  = (count >= almost_full_thr);
      almost_empty = (count <= almost_empty_thr);
      push_acc     = push & ~full;
      pop_acc      = pop & ~empty;
      write        = push_acc & reset;
      read         = pop_acc & reset;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + MAIN_SIZE'(1);
         if (pop_acc)  rd_ptr <= rd_ptr + MAIN_SIZE'(1);
         count    <= count + CW'(push_acc) - CW'(pop_acc);
         rd_valid <= pop_acc;
      end
   end

`ifdef FIFO_ERR_EN
   // Sticky until reset: a rejected request is recorded, never silently dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (push & full)  err_overflow  <= 1'b1;
         if (pop & empty)  err_underflow <= 1'b1;
      end
   end
`else
   assign err_overflow  = 1'b0;
   assign err_underflow = 1'b0;
`endif

endmodule
